// File: rtl/zmod_rx_pkg.sv
// zmod_rx_pkg: shared state encoding and default constants for the ZMOD RX alignment path
package zmod_rx_pkg;
  typedef enum logic [2:0] {WAIT_LOCK, SETTLE, CHECK, SLIP, ALIGNED, FAIL} state_t;
  localparam int ZMOD_WORD_WIDTH = 8;
  localparam logic [7:0] ZMOD_TRAIN_PATTERN = 8'h0F;
endpackage

// File: rtl/zmod_sync_bit.sv
// zmod_sync_bit: N-flop single-bit synchroniser with async active-low reset
module zmod_sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic [N-1:0] sr;
  // shift the asynchronous input through N flops
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) sr <= '0;
    else sr <= N'({sr, d});
  assign q = sr[N-1];
endmodule

// File: rtl/zmod_rx_align.sv
// zmod_rx_align: bitslip word-alignment trainer; ZMOD_RX_ALIGN_AUTO_RETRY_EN enables timed retry out of FAIL
module zmod_rx_align
  import zmod_rx_pkg::*;
#(
  parameter int WIDTH = ZMOD_WORD_WIDTH,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(ZMOD_TRAIN_PATTERN),
  parameter int SETTLE_CYCLES = 4,
  parameter int MATCH_COUNT = 16,
  parameter int MAX_SLIPS = 8,
  parameter int RETRY_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           pll_locked,
  input  logic                           retrain,
  input  logic [WIDTH-1:0]               rx_data,
  output logic                           bitslip,
  output logic                           aligned,
  output logic                           align_fail,
  output logic [$clog2(MAX_SLIPS+1)-1:0] slip_count,
  output logic [WIDTH-1:0]               data_out,
  output logic                           data_valid
);
  localparam int CW = $clog2(MAX_SLIPS + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  state_t state, nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic [MW-1:0] match_cnt, match_nxt;
  logic [CW-1:0] slip_nxt;
  logic lock_s, fail_nxt, retry_done;
  zmod_sync_bit #(.N(2)) u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pll_locked),
    .q      (lock_s)
  );
`ifdef ZMOD_RX_ALIGN_AUTO_RETRY_EN
  localparam int RW = $clog2(RETRY_CYCLES + 1);
  logic [RW-1:0] retry_cnt;
  assign retry_done = retry_cnt == RW'(RETRY_CYCLES - 1);
  // dwell counter that runs only while FAIL persists
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) retry_cnt <= '0;
    else retry_cnt <= (state == FAIL && nxt == FAIL) ? retry_cnt + 1'b1 : '0;
`else
  assign retry_done = 1'b0;
`endif
  assign bitslip = state == SLIP;
  assign aligned = state == ALIGNED;
  // next state and counter updates; lock loss outranks retrain, retrain outranks normal flow
  always_comb begin
    nxt = state;
    settle_nxt = settle_cnt;
    match_nxt = match_cnt;
    slip_nxt = slip_count;
    if (!lock_s) begin
      nxt = WAIT_LOCK;
      slip_nxt = '0;
    end else if (retrain && state != WAIT_LOCK) begin
      nxt = SETTLE;
      settle_nxt = SETTLE_LOAD;
      slip_nxt = '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          nxt = SETTLE;
          settle_nxt = SETTLE_LOAD;
          slip_nxt = '0;
        end
        SETTLE: begin
          nxt = settle_cnt == '0 ? CHECK : SETTLE;
          settle_nxt = settle_cnt == '0 ? settle_cnt : settle_cnt - 1'b1;
          match_nxt = settle_cnt == '0 ? '0 : match_cnt;
        end
        CHECK:
          if (rx_data == TRAIN_PATTERN) begin
            nxt = match_cnt == MW'(MATCH_COUNT - 1) ? ALIGNED : CHECK;
            match_nxt = match_cnt == MW'(MATCH_COUNT - 1) ? match_cnt : match_cnt + 1'b1;
          end else nxt = slip_count == CW'(MAX_SLIPS) ? FAIL : SLIP;
        SLIP: begin
          nxt = SETTLE;
          settle_nxt = SETTLE_LOAD;
          slip_nxt = slip_count == CW'(MAX_SLIPS) ? slip_count : slip_count + 1'b1;
        end
        FAIL:
          if (retry_done) begin
            nxt = SETTLE;
            settle_nxt = SETTLE_LOAD;
            slip_nxt = '0;
          end
        default: ;
      endcase
    end
    fail_nxt = nxt == FAIL ? 1'b1 : nxt == ALIGNED ? 1'b0 : align_fail;
  end
  // state, counters and registered datapath
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= WAIT_LOCK;
      settle_cnt <= '0;
      match_cnt <= '0;
      slip_count <= '0;
      align_fail <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
    end else begin
      state <= nxt;
      settle_cnt <= settle_nxt;
      match_cnt <= match_nxt;
      slip_count <= slip_nxt;
      align_fail <= fail_nxt;
      data_out <= rx_data;
      data_valid <= nxt == ALIGNED;
    end
endmodule

// File: tb/tb_zmod_rx_align.sv
// tb_zmod_rx_align: directed/randomised bench with a rotating-deserialiser model for zmod_rx_align
module tb_zmod_rx_align;
  localparam int SETTLE = 4, MATCH = 16, SLIPS = 8, RETRY = 1024;
  logic clk = 1'b0, resetn = 1'b0, pll_locked = 1'b0, retrain = 1'b0;
  logic [7:0] rx_data = 8'h00, src = 8'h0F;
  logic bitslip, aligned, align_fail, data_valid;
  logic [3:0] slip_count;
  logic [7:0] data_out;
  logic [1:0] pipe = 2'b00;
  int vectors = 0, miscompares = 0, cyc = 0, pulses = 0, last_slip = -100, rot = 0, n = 0, r0 = 0;
  logic [7:0] payload [5];
  always #5 clk = ~clk;
  zmod_rx_align dut (
    .clk        (clk),
    .resetn     (resetn),
    .pll_locked (pll_locked),
    .retrain    (retrain),
    .rx_data    (rx_data),
    .bitslip    (bitslip),
    .aligned    (aligned),
    .align_fail (align_fail),
    .slip_count (slip_count),
    .data_out   (data_out),
    .data_valid (data_valid)
  );
  function automatic logic [7:0] rotl(input logic [7:0] w, input int k);
    logic [15:0] d;
    d = {w, w} << (k % 8);
    return d[15:8];
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic apply();
    rx_data = rotl(src, rot);
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bitslip) begin
      pulses++;
      check("slip_gap", 32'(cyc - last_slip >= 5), 1);
      last_slip = cyc;
    end
    rot = rot + int'(pipe[1]);
    pipe = {pipe[0], bitslip};
    apply();
  endtask
  task automatic wait_for(input int sel, input int budget, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(sel == 0 ? aligned : sel == 1 ? align_fail : slip_count == 4'd0) && cnt < budget);
  endtask
  task automatic pulse_retrain();
    retrain = 1'b1;
    step();
    retrain = 1'b0;
  endtask
  initial begin
    apply();
    repeat (3) step();
    check("rst_aligned", aligned, 0);
    check("rst_bitslip", bitslip, 0);
    check("rst_fail", align_fail, 0);
    check("rst_slips", slip_count, 0);
    check("rst_valid", data_valid, 0);
    check("rst_data", data_out, 0);
    resetn = 1'b1;
    step();
    check("idle_aligned", aligned, 0);
    pll_locked = 1'b1;
    wait_for(0, 60, n);
    check("lock_latency", n, 2 + 1 + SETTLE + MATCH);
    check("lock_aligned", aligned, 1);
    check("lock_valid", data_valid, 1);
    check("lock_slips", slip_count, 0);
    check("lock_pulses", pulses, 0);
    check("lock_fail", align_fail, 0);
    pulse_retrain();
    check("retrain_drop", aligned, 0);
    check("retrain_drop_valid", data_valid, 0);
    wait_for(0, 60, n);
    check("retrain_latency", n, SETTLE + MATCH);
    check("retrain_aligned", aligned, 1);
    payload[0] = 8'h3C;
    payload[1] = 8'hFF;
    payload[2] = 8'h00;
    payload[3] = 8'($urandom);
    payload[4] = 8'($urandom);
    foreach (payload[i]) begin
      src = payload[i];
      apply();
      step();
      check("payload_data", data_out, payload[i]);
      check("payload_aligned", aligned, 1);
      check("payload_valid", data_valid, 1);
    end
    src = 8'h0F;
    apply();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    step();
    step();
    check("lockloss_aligned", aligned, 0);
    check("lockloss_valid", data_valid, 0);
    wait_for(0, 60, n);
    check("relock_latency", n, 1 + SETTLE + MATCH);
    check("relock_aligned", aligned, 1);
    check("relock_slips", slip_count, 0);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    step();
    pulse_retrain();
    check("prio_aligned", aligned, 0);
    wait_for(0, 60, n);
    check("prio_latency", n, 1 + SETTLE + MATCH);
    for (int k = 0; k < 4; k++) begin
      r0 = k == 0 ? 3 : int'($urandom_range(1, 7));
      rot = r0;
      pipe = 2'b00;
      apply();
      pulses = 0;
      pulse_retrain();
      wait_for(0, 300, n);
      check("rot_pulses", pulses, (8 - r0) % 8);
      check("rot_slips", slip_count, (8 - r0) % 8);
      check("rot_aligned", aligned, 1);
      check("rot_valid", data_valid, 1);
    end
    src = 8'h00;
    rot = 0;
    pipe = 2'b00;
    apply();
    pulses = 0;
    pulse_retrain();
    wait_for(1, 300, n);
    check("fail_flag", align_fail, 1);
    check("fail_aligned", aligned, 0);
    check("fail_valid", data_valid, 0);
    check("fail_pulses", pulses, SLIPS);
    check("fail_slips", slip_count, SLIPS);
`ifdef ZMOD_RX_ALIGN_AUTO_RETRY_EN
    wait_for(2, 2000, n);
    check("retry_delay", n, RETRY);
    check("retry_slips", slip_count, 0);
    check("retry_fail_held", align_fail, 1);
`else
    repeat (RETRY + 76) step();
    check("fail_terminal", align_fail, 1);
    check("fail_terminal_slips", slip_count, SLIPS);
    check("fail_terminal_pulses", pulses, SLIPS);
`endif
    src = 8'h0F;
    rot = 0;
    pipe = 2'b00;
    apply();
    pulse_retrain();
    wait_for(0, 300, n);
    check("recover_aligned", aligned, 1);
    check("recover_fail_clear", align_fail, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
